// File: rtl/y86_pkg.sv
// Shared Y86-64 opcode constants and the fetch FSM state type.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_BYTE0,
        FS_REGS,
        FS_CONST,
        FS_DONE
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Byte-wide instruction memory port: req/ack, one byte per transaction.
// Handshake: mem_req rises with a stable mem_addr and stays high until a cycle with
// mem_ack=1; that cycle carries mem_rdata and mem_err. The next request may follow immediately.
interface fetch_unit_if;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        mem_err;

    modport master (output mem_req, mem_addr, input mem_rdata, mem_ack, mem_err);
    modport slave  (input mem_req, mem_addr, output mem_rdata, mem_ack, mem_err);
endinterface

// File: rtl/instr_len_decode.sv
// Classifies an instruction byte: which trailing fields exist, and whether icode/ifun is legal.
module instr_len_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] ifun,
    output logic       need_regids,
    output logic       need_valC,
    output logic       legal
);

    always_comb begin
        need_regids = 1'b0;
        need_valC   = 1'b0;
        legal       = 1'b0;
        case (icode)
            ICODE_HALT, ICODE_NOP, ICODE_RET: legal = (ifun == 4'h0);
            ICODE_RRMOVQ: begin need_regids = 1'b1; legal = (ifun <= 4'h6); end
            ICODE_OPQ:    begin need_regids = 1'b1; legal = (ifun <= 4'h3); end
            ICODE_PUSHQ, ICODE_POPQ: begin need_regids = 1'b1; legal = (ifun == 4'h0); end
            ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ: begin
                need_regids = 1'b1;
                need_valC   = 1'b1;
                legal       = (ifun == 4'h0);
            end
            ICODE_JXX:  begin need_valC = 1'b1; legal = (ifun <= 4'h6); end
            ICODE_CALL: begin need_valC = 1'b1; legal = (ifun == 4'h0); end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetches one Y86-64 instruction byte by byte starting at pc and assembles its fields.
module fetch_unit
    import y86_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [63:0]       pc,
    fetch_unit_if.master      mem,
    output logic              busy,
    output logic              done,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [63:0]       valP,
    output logic              instr_valid,
    output logic              imem_error,
    output fetch_state_t      dbg_state
);

    fetch_state_t state, state_nxt;
    logic [63:0]  pc_q;
    logic [3:0]   off;
    logic [2:0]   cnt;
    logic [31:0]  wait_cnt;
    logic         need_valC_q;
    logic         dec_regids, dec_valC, dec_legal;
    logic         fire, fault, tmo, fail;
    logic [63:0]  addr;

    instr_len_decode u_dec (
        .icode       (mem.mem_rdata[7:4]),
        .ifun        (mem.mem_rdata[3:0]),
        .need_regids (dec_regids),
        .need_valC   (dec_valC),
        .legal       (dec_legal)
    );

    assign addr         = pc_q + {60'd0, off};
    assign busy         = (state == FS_BYTE0) || (state == FS_REGS) || (state == FS_CONST);
    assign done         = (state == FS_DONE);
    assign mem.mem_req  = busy;
    assign mem.mem_addr = addr;
    assign dbg_state    = state;

    assign fire  = mem.mem_req && mem.mem_ack;
    assign fault = fire && mem.mem_err;
    // Timeout counts only cycles without ack; the counter restarts on every completed byte.
    assign tmo   = (TIMEOUT != 0) && mem.mem_req && !mem.mem_ack
                   && (wait_cnt == 32'(TIMEOUT - 1));
    assign fail  = fault || tmo;

    always_comb begin
        state_nxt = state;
        case (state)
            FS_IDLE:  if (start) state_nxt = FS_BYTE0;
            FS_BYTE0: begin
                if (fail)                state_nxt = FS_DONE;
                else if (fire) begin
                    if (!dec_legal)      state_nxt = FS_DONE;
                    else if (dec_regids) state_nxt = FS_REGS;
                    else if (dec_valC)   state_nxt = FS_CONST;
                    else                 state_nxt = FS_DONE;
                end
            end
            FS_REGS: begin
                if (fail)      state_nxt = FS_DONE;
                else if (fire) state_nxt = need_valC_q ? FS_CONST : FS_DONE;
            end
            FS_CONST: begin
                if (fail)                         state_nxt = FS_DONE;
                else if (fire && (cnt == 3'd7))   state_nxt = FS_DONE;
            end
            FS_DONE: state_nxt = FS_IDLE;
            default: state_nxt = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FS_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= 64'd0;
            off         <= 4'd0;
            cnt         <= 3'd0;
            wait_cnt    <= 32'd0;
            need_valC_q <= 1'b0;
            icode       <= 4'h0;
            ifun        <= 4'h0;
            rA          <= REG_NONE;
            rB          <= REG_NONE;
            valC        <= 64'd0;
            valP        <= 64'd0;
            instr_valid <= 1'b0;
            imem_error  <= 1'b0;
        end else if ((state == FS_IDLE) && start) begin
            pc_q        <= pc;
            off         <= 4'd0;
            cnt         <= 3'd0;
            wait_cnt    <= 32'd0;
            need_valC_q <= 1'b0;
            icode       <= 4'h0;
            ifun        <= 4'h0;
            rA          <= REG_NONE;
            rB          <= REG_NONE;
            valC        <= 64'd0;
            valP        <= 64'd0;
            instr_valid <= 1'b0;
            imem_error  <= 1'b0;
        end else if (busy) begin
            wait_cnt <= fire ? 32'd0 : wait_cnt + 32'd1;
            if (fail) begin
                imem_error  <= 1'b1;
                instr_valid <= 1'b0;
                valP        <= pc_q + 64'd1;
            end else if (fire) begin
                off <= off + 4'd1;
                case (state)
                    FS_BYTE0: begin
                        icode       <= mem.mem_rdata[7:4];
                        ifun        <= mem.mem_rdata[3:0];
                        instr_valid <= dec_legal;
                        need_valC_q <= dec_valC;
                    end
                    FS_REGS: begin
                        rA <= mem.mem_rdata[7:4];
                        rB <= mem.mem_rdata[3:0];
                    end
                    FS_CONST: begin
                        valC[{cnt, 3'b000} +: 8] <= mem.mem_rdata;
                        cnt <= cnt + 3'd1;
                    end
                    default: ;
                endcase
                // The final byte's address plus one is pc + length (wraps mod 2^64).
                if (state_nxt == FS_DONE) valP <= addr + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: byte memory responder with wait states/faults and a field-level reference model.
module tb_fetch_unit;
  import y86_pkg::*;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic        valid;
    logic        ierr;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [63:0] pc = 64'd0;
  logic busy, done, instr_valid, imem_error;
  logic [3:0] icode, ifun, ra, rb;
  logic [63:0] valc, valp;
  fetch_state_t dbg_state;

  fetch_unit_if bus ();

  fetch_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .mem(bus),
    .busy(busy), .done(done), .icode(icode), .ifun(ifun), .rA(ra), .rB(rb),
    .valC(valc), .valP(valp), .instr_valid(instr_valid), .imem_error(imem_error),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_fail = 0;

  // memory model and responder
  logic [7:0]  mem [logic [63:0]];
  int          ack_delay = 0;
  logic        err_en = 1'b0, hang_en = 1'b0;
  logic [63:0] err_addr = 64'd0, hang_addr = 64'd0;
  logic [63:0] addr_log[$];

  function automatic logic [7:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  initial begin
    int w;
    w = 0;
    bus.mem_ack = 1'b0;
    bus.mem_err = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.mem_err = 1'b0;
      if (bus.mem_req === 1'b1) begin
        addr_log.push_back(bus.mem_addr);
        if (hang_en && bus.mem_addr == hang_addr) begin
          w = 0;
        end else if (w >= ack_delay) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = rd(bus.mem_addr);
          bus.mem_err = err_en && (bus.mem_addr == err_addr);
          w = 0;
        end else begin
          w++;
        end
      end else begin
        w = 0;
      end
    end
  end

  function automatic string fmt(input res_t r);
    return $sformatf("icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h valid=%b err=%b",
                     r.icode, r.ifun, r.ra, r.rb, r.valc, r.valp, r.valid, r.ierr);
  endfunction

  function automatic res_t observed();
    res_t o;
    o.icode = icode; o.ifun = ifun; o.ra = ra; o.rb = rb;
    o.valc = valc; o.valp = valp; o.valid = instr_valid; o.ierr = imem_error;
    return o;
  endfunction

  function automatic res_t reset_res();
    res_t r;
    r = '0;
    r.ra = 4'hF;
    r.rb = 4'hF;
    return r;
  endfunction

  // Reference: instruction fields from the Y86 length table; faults cut the fetch at byte index.
  task automatic model(input logic [63:0] p, input int err_i, input int hang_i,
                       output res_t r, output int ntx, output bit hung);
    logic [7:0] b;
    int len, max_f, k;
    bit regs;
    r = reset_res();
    r.valp = p + 64'd1;
    hung = 1'b0;
    ntx = 1;
    if (err_i == 0 || hang_i == 0) begin
      r.ierr = 1'b1;
      hung = (hang_i == 0);
      return;
    end
    b = rd(p);
    r.icode = b[7:4];
    r.ifun = b[3:0];
    case (int'(r.icode))
      0, 1, 9:        len = 1;
      2, 6, 10, 11:   len = 2;
      3, 4, 5:        len = 10;
      7, 8:           len = 9;
      default:        len = 0;
    endcase
    max_f = (r.icode == 4'h2 || r.icode == 4'h7) ? 6 : (r.icode == 4'h6) ? 3 : 0;
    if (len == 0 || int'(r.ifun) > max_f) return;
    r.valid = 1'b1;
    regs = (len == 2 || len == 10);
    for (int i = 1; i < len; i++) begin
      ntx = i + 1;
      if (i == err_i || i == hang_i) begin
        r.ierr = 1'b1;
        r.valid = 1'b0;
        hung = (i == hang_i);
        return;
      end
      b = rd(p + 64'(i));
      if (regs && i == 1) begin
        r.ra = b[7:4];
        r.rb = b[3:0];
      end else begin
        k = i - (regs ? 2 : 1);
        r.valc[8*k +: 8] = b;
      end
    end
    r.valp = p + 64'(len);
  endtask

  // driver: fault injection, byte loading, and one complete fetch
  task automatic set_faults(input logic [63:0] p, input int err_i, input int hang_i);
    err_en = (err_i >= 0);
    err_addr = p + 64'(err_i);
    hang_en = (hang_i >= 0);
    hang_addr = p + 64'(hang_i);
  endtask

  task automatic load(input logic [63:0] p, input logic [79:0] bytes_be);
    logic [79:0] v;
    v = bytes_be;
    mem.delete();
    for (int i = 0; i < 10; i++) mem[p + 64'(i)] = v[79 - 8*i -: 8];
  endtask

  task automatic run_fetch(input logic [63:0] p, output res_t o, output int cyc, output logic [1:0] post);
    addr_log.delete();
    start = 1'b1;
    pc = p;
    cyc = 0;
    while (cyc < 300) begin
      @(negedge clk);
      if (cyc == 0) start = 1'b0;
      cyc++;
      if (done === 1'b1) break;
    end
    o = observed();
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, cyc);
    end
    @(negedge clk);
    post = {done, busy};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (observed() !== reset_res()) begin
      n_fail++;
      $display("FAIL reset_fields: got %s required %s", fmt(observed()), fmt(reset_res()));
    end
    n_cmp++;
    if ({bus.mem_req, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: req/busy/done=%b required 000", {bus.mem_req, busy, done});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_irmovq();
    res_t o, e;
    int cyc, bad;
    logic [1:0] post;
    logic [63:0] exp_q[$];
    ack_delay = 0;
    set_faults(0, -1, -1);
    load(64'h100, 80'h30F3EFCDAB8967452301);
    run_fetch(64'h100, o, cyc, post);
    e = '{icode: 4'h3, ifun: 4'h0, ra: 4'hF, rb: 4'h3, valc: 64'h0123456789ABCDEF,
          valp: 64'h10A, valid: 1'b1, ierr: 1'b0};
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL irmovq_fields: got %s required %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (cyc != 11) begin n_fail++; $display("FAIL irmovq_latency: got %0d required 11", cyc); end
    n_cmp++;
    if (post !== 2'b00) begin n_fail++; $display("FAIL irmovq_done_pulse: done/busy after=%b required 00", post); end
    for (int i = 0; i < 10; i++) exp_q.push_back(64'h100 + 64'(i));
    bad = (addr_log.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && i < addr_log.size(); i++) if (addr_log[i] !== exp_q[i]) bad++;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL irmovq_addrs: %0d req cycles, %0d wrong, required 10 sequential", addr_log.size(), bad); end
  endtask

  task automatic test_jmp_wait_busy_start();
    res_t o, e;
    int cyc, bad;
    logic [1:0] post;
    logic [63:0] exp_q[$];
    ack_delay = 2;
    set_faults(0, -1, -1);
    load(64'h20, 80'h70400000000000000000);
    fork
      run_fetch(64'h20, o, cyc, post);
      begin
        repeat (5) @(negedge clk);
        start = 1'b1;
        pc = 64'h999;
        @(negedge clk);
        start = 1'b0;
      end
    join
    e = '{icode: 4'h7, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h40,
          valp: 64'h29, valid: 1'b1, ierr: 1'b0};
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL jmp_fields: got %s required %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (cyc != 28) begin n_fail++; $display("FAIL jmp_latency: got %0d required 28", cyc); end
    for (int i = 0; i < 9; i++) repeat (3) exp_q.push_back(64'h20 + 64'(i));
    bad = (addr_log.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && i < addr_log.size(); i++) if (addr_log[i] !== exp_q[i]) bad++;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL jmp_addr_stable: %0d req cycles, %0d wrong, required 27", addr_log.size(), bad); end
    ack_delay = 0;
  endtask

  task automatic test_short_and_illegal();
    logic [7:0] op [3];
    res_t ex [3];
    res_t o;
    int cyc;
    logic [1:0] post;
    op[0] = 8'h90; op[1] = 8'hC0; op[2] = 8'h27;
    ex[0] = '{icode: 4'h9, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'd0, valp: 64'h301, valid: 1'b1, ierr: 1'b0};
    ex[1] = '{icode: 4'hC, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'd0, valp: 64'h301, valid: 1'b0, ierr: 1'b0};
    ex[2] = '{icode: 4'h2, ifun: 4'h7, ra: 4'hF, rb: 4'hF, valc: 64'd0, valp: 64'h301, valid: 1'b0, ierr: 1'b0};
    ack_delay = 0;
    set_faults(0, -1, -1);
    for (int t = 0; t < 3; t++) begin
      load(64'h300, {op[t], 72'h12_3456_789A_BCDE_F011});
      run_fetch(64'h300, o, cyc, post);
      n_cmp++;
      if (o !== ex[t] || cyc != 2 || addr_log.size() != 1) begin
        n_fail++;
        $display("FAIL short_%h: got %s cyc=%0d tx=%0d required %s cyc=2 tx=1",
                 op[t], fmt(o), cyc, addr_log.size(), fmt(ex[t]));
      end
    end
  endtask

  task automatic test_wrap();
    res_t o, e;
    int cyc, nt, bad;
    bit hg;
    logic [1:0] post;
    logic [63:0] p;
    p = 64'hFFFF_FFFF_FFFF_FFFC;
    ack_delay = 0;
    set_faults(0, -1, -1);
    load(p, 80'h4012_1122_3344_5566_7788);
    run_fetch(p, o, cyc, post);
    model(p, -1, -1, e, nt, hg);
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL wrap_fields: got %s required %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (o.valp !== 64'h6) begin n_fail++; $display("FAIL wrap_valp: got %h required 6", o.valp); end
    bad = (addr_log.size() != 10);
    for (int i = 0; i < 10 && i < addr_log.size(); i++) if (addr_log[i] !== p + 64'(i)) bad++;
    n_cmp++;
    if (bad != 0 || addr_log[4] !== 64'h0) begin n_fail++; $display("FAIL wrap_addrs: %0d wrong, addr[4]=%h required 0", bad, addr_log[4]); end
  endtask

  task automatic test_faults();
    res_t o, e;
    int cyc;
    logic [1:0] post;
    ack_delay = 0;
    load(64'h500, 80'h5012_8877_6655_4433_2211);
    set_faults(64'h500, 2, -1);
    run_fetch(64'h500, o, cyc, post);
    e = '{icode: 4'h5, ifun: 4'h0, ra: 4'h1, rb: 4'h2, valc: 64'd0, valp: 64'h501, valid: 1'b0, ierr: 1'b1};
    n_cmp++;
    if (o !== e || cyc != 4) begin n_fail++; $display("FAIL mem_err: got %s cyc=%0d required %s cyc=4", fmt(o), cyc, fmt(e)); end
    load(64'h600, 80'h2034_0000_0000_0000_0000);
    set_faults(64'h600, -1, 1);
    run_fetch(64'h600, o, cyc, post);
    e = '{icode: 4'h2, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'd0, valp: 64'h601, valid: 1'b0, ierr: 1'b1};
    n_cmp++;
    if (o !== e || cyc != 18) begin n_fail++; $display("FAIL timeout: got %s cyc=%0d required %s cyc=18", fmt(o), cyc, fmt(e)); end
    n_cmp++;
    if (post !== 2'b00) begin n_fail++; $display("FAIL timeout_done_pulse: done/busy after=%b required 00", post); end
    set_faults(0, -1, -1);
  endtask

  task automatic test_reset_mid_fetch();
    res_t o, e;
    int cyc, k;
    logic [1:0] post;
    ack_delay = 1;
    set_faults(0, -1, -1);
    load(64'h100, 80'h30F3EFCDAB8967452301);
    start = 1'b1;
    pc = 64'h100;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (dbg_state !== FS_CONST && k < 50) begin @(negedge clk); k++; end
    n_cmp++;
    if (dbg_state !== FS_CONST) begin n_fail++; $display("FAIL reach_const: state=%0d required %0d", dbg_state, FS_CONST); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_req, busy} !== 2'b00) begin n_fail++; $display("FAIL async_reset_req: req/busy=%b required 00", {bus.mem_req, busy}); end
    n_cmp++;
    if (observed() !== reset_res()) begin n_fail++; $display("FAIL async_reset_fields: got %s required %s", fmt(observed()), fmt(reset_res())); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ack_delay = 0;
    run_fetch(64'h100, o, cyc, post);
    e = '{icode: 4'h3, ifun: 4'h0, ra: 4'hF, rb: 4'h3, valc: 64'h0123456789ABCDEF,
          valp: 64'h10A, valid: 1'b1, ierr: 1'b0};
    n_cmp++;
    if (o !== e || cyc != 11) begin n_fail++; $display("FAIL post_reset_fetch: got %s cyc=%0d required %s cyc=11", fmt(o), cyc, fmt(e)); end
  endtask

  task automatic test_random();
    res_t o, e;
    int cyc, nt, mode, ei, hi, expc;
    bit hg;
    logic [1:0] post;
    logic [63:0] p;
    logic [7:0] b0;
    for (int it = 0; it < 40; it++) begin
      p = ($urandom_range(0, 4) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15)))
                                      : {$urandom, $urandom};
      mem.delete();
      b0 = {4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15))};
      mem[p] = b0;
      for (int i = 1; i < 10; i++) mem[p + 64'(i)] = 8'($urandom);
      ack_delay = $urandom_range(0, 2);
      mode = $urandom_range(0, 7);
      ei = (mode == 0) ? $urandom_range(0, 9) : -1;
      hi = (mode == 1) ? $urandom_range(0, 9) : -1;
      set_faults(p, ei, hi);
      run_fetch(p, o, cyc, post);
      model(p, ei, hi, e, nt, hg);
      expc = (nt - 1) * (ack_delay + 1) + (hg ? 16 : ack_delay + 1) + 1;
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL rand%0d_fields: got %s required %s", it, fmt(o), fmt(e)); end
      n_cmp++;
      if (cyc != expc || post !== 2'b00) begin
        n_fail++;
        $display("FAIL rand%0d_timing: cyc=%0d post=%b required cyc=%0d post=00", it, cyc, post, expc);
      end
    end
    set_faults(0, -1, -1);
    ack_delay = 0;
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_jmp_wait_busy_start();
    test_short_and_illegal();
    test_wrap();
    test_faults();
    test_reset_mid_fetch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Reader of the program counter: takes the PC produced by the PC-update stage and fetches one Y86-64 instruction from a byte-wide instruction memory.
- Uses a req/ack handshake, one byte per transaction. Assembles icode, ifun, rA, rB, valC and valP, then pulses done.
- Sits between the PC register and decode in the SEQ datapath; the sequencer starts it once per instruction.

Parameters:
- TIMEOUT, 16, max cycles mem_req may wait for mem_ack before a fetch error is flagged; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin fetch at pc; ignored unless idle.
- pc  in  64  address of the instruction, sampled when start is accepted.
- mem_req  out  1  byte read request, held until mem_ack.
- mem_addr  out  64  byte address, stable while mem_req is high.
- mem_rdata  in  8  read data, valid in a cycle with mem_ack=1.
- mem_ack  in  1  completes the current byte transaction.
- mem_err  in  1  qualifies mem_ack: the access faulted.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle until the next accepted start.
- icode  out  4  opcode (byte0[7:4]).
- ifun  out  4  function (byte0[3:0]).
- rA  out  4  register byte[7:4]; 4'hF if the instruction has no register byte.
- rB  out  4  register byte[3:0]; 4'hF if the instruction has no register byte.
- valC  out  64  little-endian constant; 0 if the instruction has no constant.
- valP  out  64  pc + instruction length, modulo 2^64.
- instr_valid  out  1  icode/ifun is legal.
- imem_error  out  1  mem_err seen or timeout expired.

Behaviour:
- Reset (async, any state): FSM returns to IDLE and mem_req drops immediately. All outputs reset to 0 except rA and rB, which reset to 4'hF. An in-flight transaction is abandoned.
- FSM states: IDLE, BYTE0, REGS, CONST, DONE.
- IDLE: start=1 latches pc, sets busy, goes to BYTE0. Outputs from the previous fetch are held.
- Handshake, every fetch state: mem_req=1 with mem_addr = pc + byte offset. Data is captured on the mem_ack cycle. mem_req may stay high back-to-back into the next byte.
- BYTE0: captures icode/ifun. Length class by icode:
  - 0, 1, 9: 1 byte.
  - 2, 6, A, B: 2 bytes (register byte only).
  - 3, 4, 5: 10 bytes (register byte + constant).
  - 7, 8: 9 bytes (constant only).
  - Next state is REGS if a register byte is needed, else CONST if a constant is needed, else DONE.
- Illegal opcode: icode > B, or ifun outside the legal set. Legal ifun is 0..6 for icode 2 and 7, 0..3 for icode 6, and 0 for all others. Result: instr_valid=0, length 1, go directly to DONE.
- REGS: captures rA and rB, then goes to CONST or DONE.
- CONST: 8 transactions, byte k → valC[8k+7:8k]. A 3-bit counter wraps to DONE after k=7.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start is not accepted in DONE.
- Latency with zero-wait memory: done asserts N+1 cycles after the start cycle (N = instruction length).
- mem_err on an ack cycle, or TIMEOUT consecutive req cycles without ack:
  - imem_error=1, instr_valid=0.
  - Fields not yet fetched keep their defaults (rA/rB=F, valC=0); valP = pc+1.
  - Go to DONE.
- Address arithmetic is modulo 2^64; a fetch crossing 0xFFFF_FFFF_FFFF_FFFF wraps to 0. valP wraps the same way.
- start while busy is ignored; no queuing.

Decomposition:
- Package y86_pkg: ICODE_* constants (HALT..POPQ), REG_NONE=4'hF, fetch FSM state enum.
- One combinational sub-module, instr_len_decode: icode, ifun → need_regids, need_valC, legal.

Test Plan:
- Zero-wait memory, pc=0x100, bytes 30 F3 EF CD AB 89 67 45 23 01 (irmovq) → done at start+11; icode=3, rA=F, rB=3, valC=0x0123456789ABCDEF, valP=0x10A, instr_valid=1.
- pc=0x20, byte 0x70 followed by 8 bytes of 0x40 00.. (jmp 0x40) with 2-cycle ack delay per byte → valC=0x40, valP=0x29, rA=rB=F, mem_addr increments 0x20..0x28 and stays stable through each wait.
- Byte 0x90 (ret) → one transaction, done at start+2, valP=pc+1. Byte 0xC0 → instr_valid=0, valP=pc+1. Byte 0x27 → instr_valid=0.
- rmmovq at pc=0xFFFF_FFFF_FFFF_FFFC → mem_addr wraps 0xFFFF_FFFF_FFFF_FFFF→0x0, valP=0x6.
- mem_err on byte 2 of mrmovq → imem_error=1, instr_valid=0, valC=0, done pulses. Separately: no ack for 16 cycles with TIMEOUT=16 → imem_error=1.
- rst_n low while in CONST → mem_req=0 in the same cycle; outputs reset; next start fetches cleanly. start pulsed while busy → no effect on mem_addr.
